// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage: operand forwarding, ALU, BEQ resolve, EX/MEM register.
// Optional macro EXECUTE_FORWARD_EN enables the hazard-unit forward muxes on SrcA/SrcB.
module execute_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ALUSrcE,
    input  logic                  MemWriteE,
    input  logic                  ResultSrcE,
    input  logic                  BranchE,
    input  logic [2:0]            ALUControlE,
    input  logic [XLEN-1:0]       RD1E,
    input  logic [XLEN-1:0]       RD2E,
    input  logic [XLEN-1:0]       ImmExtE,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RDE,
    input  logic [XLEN-1:0]       ResultW,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [REG_ADDR_W-1:0] RDM,
    output logic [XLEN-1:0]       PCPlus4M
);

    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] fwdB;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] aluResult;
    logic            zero;

`ifdef EXECUTE_FORWARD_EN
    // ALUResultM is the registered output of this stage, so feeding it back is loop-free.
    always_comb begin
        srcA = RD1E;
        case (ForwardAE)
            2'b01:   srcA = ResultW;
            2'b10:   srcA = ALUResultM;
            default: srcA = RD1E;
        endcase
    end

    always_comb begin
        fwdB = RD2E;
        case (ForwardBE)
            2'b01:   fwdB = ResultW;
            2'b10:   fwdB = ALUResultM;
            default: fwdB = RD2E;
        endcase
    end
`else
    logic unusedFwdInputs;
    assign unusedFwdInputs = ^{ForwardAE, ForwardBE, ResultW};
    assign srcA = RD1E;
    assign fwdB = RD2E;
`endif

    assign srcB = ALUSrcE ? ImmExtE : fwdB;

    always_comb begin
        aluResult = '0;
        case (ALUControlE)
            3'b000:  aluResult = srcA + srcB;
            3'b001:  aluResult = srcA - srcB;
            3'b010:  aluResult = srcA & srcB;
            3'b011:  aluResult = srcA | srcB;
            3'b101:  aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            default: aluResult = '0;
        endcase
    end

    // BEQ is decoded as a subtract, so equality shows up as a zero result.
    assign zero      = (aluResult == '0);
    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + ImmExtE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            RDM        <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= aluResult;
            WriteDataM <= fwdB;
            RDM        <= RDE;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RDE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RDM;

    int total = 0;
    int bad   = 0;

    execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RDE(RDE), .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RDM(RDM), .PCPlus4M(PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'b000; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0;
        RDE = 0; ResultW = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    task automatic runAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expected, input string name);
        ALUControlE = op; RD1E = a; RD2E = b; ALUSrcE = 0;
        @(posedge clk); #1;
        total++;
        if (ALUResultM !== expected) begin
            bad++;
            $display("FAIL %s: ALUResultM=%h expected=%h", name, ALUResultM, expected);
        end
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1;
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD1E = 5; RD2E = 7; RDE = 9;
        PCPlus4E = 32'h24; PCE = 32'h20; ImmExtE = 32'h8;
        @(posedge clk); #1;
        #2 rst = 0;
        #1;
        total++;
        if ({RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RDM, PCPlus4M} !== '0) begin
            bad++;
            $display("FAIL reset_async: ALUResultM=%h RDM=%h PCPlus4M=%h ctl=%b expected all zero",
                     ALUResultM, RDM, PCPlus4M, {RegWriteM, MemWriteM, ResultSrcM});
        end
        total++;
        if (PCTargetE !== 32'h28) begin
            bad++;
            $display("FAIL reset_pctarget: PCTargetE=%h expected=00000028", PCTargetE);
        end
        @(posedge clk); #1;
        total++;
        if ({RegWriteM, ALUResultM, RDM, PCPlus4M} !== '0) begin
            bad++;
            $display("FAIL reset_held: ALUResultM=%h RDM=%h expected zero", ALUResultM, RDM);
        end
        #2 rst = 1;
        @(posedge clk); #1;
        total++;
        if (ALUResultM !== 32'd12 || RDM !== 5'd9 || PCPlus4M !== 32'h24 ||
            {RegWriteM, MemWriteM, ResultSrcM} !== 3'b111 || WriteDataM !== 32'd7) begin
            bad++;
            $display("FAIL reset_release_load: ALUResultM=%h RDM=%h PCPlus4M=%h ctl=%b WD=%h expected 0000000c 09 00000024 111 00000007",
                     ALUResultM, RDM, PCPlus4M, {RegWriteM, MemWriteM, ResultSrcM}, WriteDataM);
        end
    endtask

    task automatic test_add();
        clearInputs();
        RegWriteE = 1; RDE = 3;
        runAlu(3'b000, 32'd5, 32'd7, 32'd12, "add_5_7");
        total++;
        if (RDM !== 5'd3 || RegWriteM !== 1'b1 || MemWriteM !== 1'b0) begin
            bad++;
            $display("FAIL add_ctl: RDM=%h RegWriteM=%b MemWriteM=%b expected 03 1 0", RDM, RegWriteM, MemWriteM);
        end
    endtask

    task automatic test_alu_ops();
        clearInputs();
        runAlu(3'b101, 32'hFFFFFFFF, 32'd1, 32'd1, "slt_neg");
        runAlu(3'b101, 32'd1, 32'hFFFFFFFF, 32'd0, "slt_pos");
        runAlu(3'b001, 32'd0, 32'd1, 32'hFFFFFFFF, "sub_wrap");
        runAlu(3'b111, 32'h1234, 32'h5678, 32'd0, "op_111");
        runAlu(3'b100, 32'h1234, 32'h5678, 32'd0, "op_100");
        runAlu(3'b010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, "and");
        runAlu(3'b011, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, "or");
        runAlu(3'b000, 32'hFFFFFFFF, 32'd2, 32'd1, "add_wrap");
        ALUSrcE = 1; ImmExtE = 32'd100; RD1E = 32'd5; RD2E = 32'd7; ALUControlE = 3'b000;
        @(posedge clk); #1;
        total++;
        if (ALUResultM !== 32'd105 || WriteDataM !== 32'd7) begin
            bad++;
            $display("FAIL alusrc_imm: ALUResultM=%h WriteDataM=%h expected 00000069 00000007", ALUResultM, WriteDataM);
        end
    endtask

    task automatic test_branch();
        clearInputs();
        ALUControlE = 3'b001; BranchE = 1; RD1E = 32'h10; RD2E = 32'h10;
        PCE = 32'h100; ImmExtE = 32'hFFFFFFF0;
        #1;
        total++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h000000F0) begin
            bad++;
            $display("FAIL beq_taken: PCSrcE=%b PCTargetE=%h expected 1 000000f0", PCSrcE, PCTargetE);
        end
        RD2E = 32'h11;
        #1;
        total++;
        if (PCSrcE !== 1'b0) begin
            bad++;
            $display("FAIL beq_not_taken: PCSrcE=%b expected 0", PCSrcE);
        end
        RD2E = 32'h10; BranchE = 0;
        #1;
        total++;
        if (PCSrcE !== 1'b0) begin
            bad++;
            $display("FAIL no_branch: PCSrcE=%b expected 0", PCSrcE);
        end
        PCE = 32'hFFFFFFFC; ImmExtE = 32'd8;
        #1;
        total++;
        if (PCTargetE !== 32'h00000004) begin
            bad++;
            $display("FAIL pc_wrap: PCTargetE=%h expected 00000004", PCTargetE);
        end
    endtask

    task automatic test_x0();
        clearInputs();
        RegWriteE = 1; RDE = 5'd0;
        runAlu(3'b000, 32'd1, 32'd1, 32'd2, "x0_result");
        total++;
        if (RDM !== 5'd0 || RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL x0_passthru: RDM=%h RegWriteM=%b expected 00 1", RDM, RegWriteM);
        end
    endtask

    task automatic test_forward();
        clearInputs();
        runAlu(3'b000, 32'h50, 32'h05, 32'h55, "fwd_setup");
`ifdef EXECUTE_FORWARD_EN
        ResultW = 32'hAA; ForwardAE = 2'b10; ForwardBE = 2'b01;
        runAlu(3'b000, 32'd1, 32'd2, 32'hFF, "fwd_a10_b01");
        ForwardAE = 2'b00; ForwardBE = 2'b01; ALUSrcE = 1; ImmExtE = 32'd4;
        RD1E = 32'h100; MemWriteE = 1;
        @(posedge clk); #1;
        total++;
        if (WriteDataM !== 32'hAA || ALUResultM !== 32'h104) begin
            bad++;
            $display("FAIL fwd_store: WriteDataM=%h ALUResultM=%h expected 000000aa 00000104", WriteDataM, ALUResultM);
        end
        ForwardAE = 2'b11; ForwardBE = 2'b11; ALUSrcE = 0; MemWriteE = 0;
        runAlu(3'b000, 32'd20, 32'd22, 32'd42, "fwd_11_reg");
`else
        ResultW = 32'hAA; ForwardAE = 2'b10; ForwardBE = 2'b01;
        runAlu(3'b000, 32'd1, 32'd2, 32'd3, "nofwd_ignored");
        ALUSrcE = 1; ImmExtE = 32'd4; RD1E = 32'h100; RD2E = 32'h2; MemWriteE = 1;
        @(posedge clk); #1;
        total++;
        if (WriteDataM !== 32'h2 || ALUResultM !== 32'h104) begin
            bad++;
            $display("FAIL nofwd_store: WriteDataM=%h ALUResultM=%h expected 00000002 00000104", WriteDataM, ALUResultM);
        end
`endif
    endtask

    initial begin
        clearInputs();
        rst = 1;
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_x0();
        test_forward();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
